// File: rtl/register_bank_mp.sv
// Multi-port register bank: two combinational read ports and two write ports.
// It also keeps a per-register pending-write scoreboard, with an optional zero register and write-to-read bypass.
module register_bank_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] regS,
    input  logic [ADDR_WIDTH-1:0] regT,
    output logic [DATA_WIDTH-1:0] regA,
    output logic [DATA_WIDTH-1:0] regB,
    output logic                  busyS,
    output logic                  busyT,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] regD,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite2,
    input  logic [ADDR_WIDTH-1:0] regD2,
    input  logic [DATA_WIDTH-1:0] writeData2,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserveAddr
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wrEn1;
    logic                  wrEn2;
    logic                  rsvEn;
    logic [ADDR_WIDTH-1:0] rdAddr [2];
    logic [DATA_WIDTH-1:0] rdData [2];
    logic                  rdBusy [2];

    // An address is live when it names a real register that is not the hardwired zero.
    function automatic logic isLive(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wrEn1 = regWrite  && isLive(regD);
    assign wrEn2 = regWrite2 && isLive(regD2);
    assign rsvEn = reserve   && isLive(reserveAddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrEn1 && regD == ADDR_WIDTH'(i)) begin
                    mem[i] <= writeData;
                end else if (wrEn2 && regD2 == ADDR_WIDTH'(i)) begin
                    mem[i] <= writeData2;
                end
            end
        end
    end

    // A new reservation beats the clear of the writeback it is replacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rsvEn && reserveAddr == ADDR_WIDTH'(i)) begin
                    busy[i] <= 1'b1;
                end else if (wrEn2 && regD2 == ADDR_WIDTH'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign rdAddr[0] = regS;
    assign rdAddr[1] = regT;

    // No handshakes: every input is sampled at each edge and reads are purely combinational.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (rst_n && isLive(rdAddr[p])) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rdAddr[p] == ADDR_WIDTH'(i)) begin
                        rdData[p] = mem[i];
                        rdBusy[p] = busy[i];
                    end
                end
                if (BYPASS != 0) begin
                    if (wrEn2 && regD2 == rdAddr[p]) begin
                        rdData[p] = writeData2;
                    end
                    if (wrEn1 && regD == rdAddr[p]) begin
                        rdData[p] = writeData;
                    end
                end
            end
        end
    end

    assign regA  = rdData[0];
    assign regB  = rdData[1];
    assign busyS = rdBusy[0];
    assign busyT = rdBusy[1];

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: default bank, a BYPASS=0 bank and a 24-register bank without zero register,
// all three driven by the same stimulus.
module tb_register_bank_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  regS = '0, regT = '0, regD = '0, regD2 = '0, reserveAddr = '0;
    logic        regWrite = 1'b0, regWrite2 = 1'b0, reserve = 1'b0;
    logic [31:0] writeData = '0, writeData2 = '0;
    logic [31:0] regA, regB, regANb, regBNb, regASm, regBSm;
    logic        busyS, busyT, busySNb, busyTNb, busySSm, busyTSm;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    register_bank_mp dut (
        .clk(clk), .rst_n(rst_n), .regS(regS), .regT(regT), .regA(regA), .regB(regB),
        .busyS(busyS), .busyT(busyT), .regWrite(regWrite), .regD(regD), .writeData(writeData),
        .regWrite2(regWrite2), .regD2(regD2), .writeData2(writeData2),
        .reserve(reserve), .reserveAddr(reserveAddr)
    );

    register_bank_mp #(.BYPASS(0)) dutNb (
        .clk(clk), .rst_n(rst_n), .regS(regS), .regT(regT), .regA(regANb), .regB(regBNb),
        .busyS(busySNb), .busyT(busyTNb), .regWrite(regWrite), .regD(regD), .writeData(writeData),
        .regWrite2(regWrite2), .regD2(regD2), .writeData2(writeData2),
        .reserve(reserve), .reserveAddr(reserveAddr)
    );

    register_bank_mp #(.NUM_REGS(24), .ZERO_REG(0)) dutSm (
        .clk(clk), .rst_n(rst_n), .regS(regS), .regT(regT), .regA(regASm), .regB(regBSm),
        .busyS(busySSm), .busyT(busyTSm), .regWrite(regWrite), .regD(regD), .writeData(writeData),
        .regWrite2(regWrite2), .regD2(regD2), .writeData2(writeData2),
        .reserve(reserve), .reserveAddr(reserveAddr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0;
        regWrite2 = 1'b0;
        reserve = 1'b0;
    endtask

    initial begin
        // Reset: outputs are zero even with a bypassable write presented.
        regWrite = 1'b1; regD = 5'd3; writeData = 32'h1234; regS = 5'd3; regT = 5'd2;
        #2;
        check("rst_regA", regA, 32'h0);
        check("rst_regB", regB, 32'h0);
        check("rst_busyS", {31'b0, busyS}, 32'h0);
        check("rst_busyT", {31'b0, busyT}, 32'h0);
        tick();
        check("rst_discard_write", regA, 32'h0);
        idle();
        #3 rst_n = 1'b1;

        // Basic write via port 1.
        tick();
        regWrite = 1'b1; regD = 5'd3; writeData = 32'h1;
        tick();
        idle(); regS = 5'd3; regT = 5'd2;
        #1;
        check("basic_regA", regA, 32'h1);
        check("basic_regB", regB, 32'h0);
        check("basic_regA_nb", regANb, 32'h1);

        // Same-cycle bypass versus no bypass.
        regWrite = 1'b1; regD = 5'd5; writeData = 32'hDEADBEEF; regS = 5'd5;
        #1;
        check("bypass_regA", regA, 32'hDEADBEEF);
        check("nobypass_regA_old", regANb, 32'h0);
        tick();
        idle();
        #1;
        check("bypass_regA_after", regA, 32'hDEADBEEF);
        check("nobypass_regA_after", regANb, 32'hDEADBEEF);

        // Dual-write conflict: port 1 wins in storage and in the bypass path.
        regWrite = 1'b1; regD = 5'd7; writeData = 32'h11;
        regWrite2 = 1'b1; regD2 = 5'd7; writeData2 = 32'h22; regS = 5'd7;
        #1;
        check("dual_bypass_prio", regA, 32'h11);
        tick();
        regWrite = 1'b0; regD2 = 5'd8; writeData2 = 32'h22; regT = 5'd8;
        #1;
        check("port2_bypass", regB, 32'h22);
        check("port2_nobypass_old", regBNb, 32'h0);
        tick();
        idle();
        #1;
        check("dual_reg7", regA, 32'h11);
        check("dual_reg7_nb", regANb, 32'h11);
        check("port2_reg8", regB, 32'h22);

        // Zero register, and register 0 as a normal register when ZERO_REG=0.
        regWrite = 1'b1; regD = 5'd0; writeData = 32'hFFFFFFFF;
        reserve = 1'b1; reserveAddr = 5'd0; regS = 5'd0;
        #1;
        check("zero_bypass_regA", regA, 32'h0);
        check("nozero_bypass_regA", regASm, 32'hFFFFFFFF);
        tick();
        idle();
        #1;
        check("zero_regA", regA, 32'h0);
        check("zero_busyS", {31'b0, busyS}, 32'h0);
        check("nozero_regA", regASm, 32'hFFFFFFFF);
        check("nozero_busyS", {31'b0, busySSm}, 32'h1);

        // Out-of-range address on the 24-register bank.
        regWrite = 1'b1; regD = 5'd25; writeData = 32'hAB;
        reserve = 1'b1; reserveAddr = 5'd25; regS = 5'd25;
        #1;
        check("oor_bypass_regA", regASm, 32'h0);
        check("inrange_bypass_regA", regA, 32'hAB);
        tick();
        idle();
        #1;
        check("oor_regA", regASm, 32'h0);
        check("oor_busyS", {31'b0, busySSm}, 32'h0);
        check("inrange_busyS", {31'b0, busyS}, 32'h1);

        // Pending-write scoreboard.
        reserve = 1'b1; reserveAddr = 5'd9; regS = 5'd9;
        #1;
        check("rsv_busy_before", {31'b0, busyS}, 32'h0);
        tick();
        idle();
        #1;
        check("rsv_busy_after", {31'b0, busyS}, 32'h1);
        regWrite2 = 1'b1; regD2 = 5'd9; writeData2 = 32'h5A;
        #1;
        check("clr_no_busy_bypass", {31'b0, busyS}, 32'h1);
        check("clr_data_bypass", regA, 32'h5A);
        tick();
        idle();
        #1;
        check("clr_busy_after", {31'b0, busyS}, 32'h0);
        check("clr_regA", regA, 32'h5A);
        reserve = 1'b1; reserveAddr = 5'd9;
        regWrite2 = 1'b1; regD2 = 5'd9; writeData2 = 32'h77;
        tick();
        idle();
        #1;
        check("set_wins_busy", {31'b0, busyS}, 32'h1);
        check("set_wins_regA", regA, 32'h77);
        check("port1_keeps_busy_pre", {31'b0, busyS}, 32'h1);
        regWrite = 1'b1; regD = 5'd9; writeData = 32'h99;
        tick();
        idle();
        #1;
        check("port1_keeps_busy", {31'b0, busyS}, 32'h1);

        // Fill 1..31 with their index, reserve 4 and 6, read back.
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; regD = 5'(i); writeData = 32'(i);
            exp_q.push_back(32'(i));
            tick();
        end
        idle();
        reserve = 1'b1; reserveAddr = 5'd4;
        tick();
        reserveAddr = 5'd6;
        tick();
        idle();
        for (int i = 1; i < 32; i++) begin
            regS = 5'(i);
            #1;
            check("fill_readback", regA, exp_q.pop_front());
        end
        regS = 5'd4; regT = 5'd6;
        #1;
        check("fill_busyS4", {31'b0, busyS}, 32'h1);
        check("fill_busyT6", {31'b0, busyT}, 32'h1);
        check("fill_regB6", regB, 32'h6);

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        #1;
        check("midrst_regA", regA, 32'h0);
        check("midrst_regB", regB, 32'h0);
        check("midrst_busyS", {31'b0, busyS}, 32'h0);
        check("midrst_busyT", {31'b0, busyT}, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 1; i < 32; i++) begin
            regS = 5'(i); regT = 5'(31 - i);
            #1;
            check("postrst_regA", regA, 32'h0);
            check("postrst_busyS", {31'b0, busyS}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank_mp.md
# register_bank_mp

Parametrised multi-port register bank for the 32-bit processor datapath, replacing the fixed 32x32 bank with one write port. It adds:
- a second write port for load/multicycle writeback;
- an optional hardwired zero register;
- optional same-cycle write-to-read bypass;
- a per-register pending (busy) scoreboard that decode uses to stall on outstanding writebacks.

Sits between decode (read ports, reservations) and the ALU/memory writeback stages.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of registers (2..2^ADDR_WIDTH)
- ADDR_WIDTH, 5, register address width
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- regS  input  ADDR_WIDTH  read address A
- regT  input  ADDR_WIDTH  read address B
- regA  output  DATA_WIDTH  read data A
- regB  output  DATA_WIDTH  read data B
- busyS  output  1  pending-write flag of regS
- busyT  output  1  pending-write flag of regT
- regWrite  input  1  write enable, port 1 (ALU writeback)
- regD  input  ADDR_WIDTH  write address, port 1
- writeData  input  DATA_WIDTH  write data, port 1
- regWrite2  input  1  write enable, port 2 (load/multicycle writeback); also clears busy
- regD2  input  ADDR_WIDTH  write address, port 2
- writeData2  input  DATA_WIDTH  write data, port 2
- reserve  input  1  set busy flag of reserveAddr
- reserveAddr  input  ADDR_WIDTH  register to mark pending

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops plus NUM_REGS busy bits. No RAM inference required.
- Reads are combinational.
  - regA = mem[regS]; with BYPASS=1 an enabled same-cycle write to regS forwards its data.
  - regB is identical for regT.
- Bypass priority: port 1 over port 2 over stored value.
- Write:
  - Each enabled port writes on the rising edge.
  - Both ports to the same address: port 1 data wins.
- Busy flags:
  - reserve sets busy[reserveAddr].
  - regWrite2 clears busy[regD2].
  - Same register set and cleared in one cycle: set wins, end state busy=1 (new reservation).
  - Port 1 writes never touch busy.
  - busyS/busyT show the registered flag only. There is no bypass of the same-cycle clear.
- ZERO_REG=1:
  - address 0 reads 0 regardless of bypass;
  - writes to address 0 are discarded;
  - reserve of 0 ignored; busy[0] is constantly 0.
- Out-of-range addresses (>= NUM_REGS):
  - reads return 0, busy 0;
  - writes and reserves ignored.
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0. regA, regB, busyS, busyT therefore read 0 while in reset. Reset asserted mid-write discards that write.

## Timing
- Read latency: 0 cycles (combinational from regS/regT and, with BYPASS, from write ports).
- Write latency: 1 cycle. Data is visible through storage from the cycle after the edge.
- BYPASS=0: a read of the register being written returns the old value until the next cycle.
- Busy latency: reserve at edge N, so busyS/busyT high from cycle N+1. A clear by regWrite2 at edge N drops busy from cycle N+1.
- No handshakes. Inputs sampled every edge; enables are level, single-cycle.
- Reset release is synchronous to clk in the system. The block needs no extra wait cycles.

## Test plan
- Reset/basic:
  - rst_n low: regA=regB=0, busyS=busyT=0.
  - Release, write reg3=1 via port 1, then regS=3, regT=2: regA=1, regB=0.
- Bypass:
  - BYPASS=1, regWrite=1, regD=5, writeData=0xDEADBEEF, regS=5 same cycle: regA=0xDEADBEEF before the edge.
  - Repeat with BYPASS=0: regA=old value (0), 0xDEADBEEF next cycle.
- Dual-write conflict:
  - port 1 reg7=0x11 and port 2 reg7=0x22 same edge: reg7 reads 0x11.
  - Next cycle, port 2 only to reg8=0x22: reg8=0x22.
- Zero register:
  - ZERO_REG=1, write reg0=0xFFFFFFFF and reserve reg0: regA(regS=0)=0, busyS=0, also with bypass active.
- Scoreboard:
  - reserve reg9: busyS high next cycle.
  - regWrite2 reg9=0x5A: busy low next cycle, regA=0x5A.
  - Reserve and clear reg9 same edge: busy stays 1.
- Reset mid-operation:
  - fill regs 1..31 with index values, reserve regs 4 and 6.
  - Pulse rst_n low between edges: all reads 0 and busy 0 immediately, nothing restored after release.
